fp_compare_pipe: RTL and testbench

FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

---
 rtl/fp_compare_pipe.sv | 140 ++++++++++++++
 tb/tb_fp_compare_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// Pipelined floating-point comparator with a valid/ready handshake (GE/GT/LE/LT/EQ/NE/MIN/MAX).
// Define FP_COMPARE_UNORD_EN to add the 'unord' output, which flags a NaN operand.
module fp_compare_pipe #(
    parameter int WE     = 11,
    parameter int WF     = 11,
    parameter int STAGES = 2,
    localparam int W     = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FP_COMPARE_UNORD_EN
    output logic         unord,
`endif
    output logic         flag,
    output logic [W-1:0] res
);

    localparam logic [2:0] OP_GE  = 3'b000;
    localparam logic [2:0] OP_GT  = 3'b001;
    localparam logic [2:0] OP_LE  = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_NE  = 3'b101;
    localparam logic [2:0] OP_MIN = 3'b110;

    // Total order rank: -inf < -normal < zero < +normal < +inf (NaN is handled separately).
    function automatic logic [2:0] rank(input logic [1:0] exn, input logic sgn);
        case (exn)
            2'b01:   rank = sgn ? 3'd1 : 3'd3;
            2'b10:   rank = sgn ? 3'd0 : 3'd4;
            default: rank = 3'd2;
        endcase
    endfunction

    logic [1:0]       a_exn, b_exn;
    logic             a_sgn, b_sgn;
    logic [WE+WF-1:0] a_mag, b_mag;
    logic [2:0]       a_rank, b_rank;
    logic             a_nan, b_nan, any_nan;
    logic             both_norm, mag_eq, mag_lt;
    logic             eq, lt, sel_a;
    logic             flag_d;
    logic [W-1:0]     res_d;

    logic              en;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] flag_q;
    logic [W-1:0]      res_q [STAGES];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        a_exn     = inA[W-1:W-2];
        b_exn     = inB[W-1:W-2];
        a_sgn     = inA[W-3];
        b_sgn     = inB[W-3];
        a_mag     = inA[WE+WF-1:0];
        b_mag     = inB[WE+WF-1:0];
        a_rank    = rank(a_exn, a_sgn);
        b_rank    = rank(b_exn, b_sgn);
        a_nan     = (a_exn == 2'b11);
        b_nan     = (b_exn == 2'b11);
        any_nan   = a_nan || b_nan;
        both_norm = (a_rank == b_rank) && (a_exn == 2'b01);
        mag_eq    = (a_mag == b_mag);
        mag_lt    = (a_mag < b_mag);

        // Equal-sign normals compare by magnitude, reversed when negative.
        eq = (a_rank == b_rank) && (!both_norm || mag_eq);
        lt = (a_rank < b_rank)
             || (both_norm && (a_sgn ? (!mag_lt && !mag_eq) : mag_lt));

        sel_a  = 1'b1;
        flag_d = 1'b0;
        res_d  = inA;
        case (op)
            OP_GE: flag_d = !any_nan && !lt;
            OP_GT: flag_d = !any_nan && !lt && !eq;
            OP_LE: flag_d = !any_nan && (lt || eq);
            OP_LT: flag_d = !any_nan && lt;
            OP_EQ: flag_d = !any_nan && eq;
            OP_NE: flag_d = any_nan || !eq;
            default: begin
                if (a_nan && b_nan)  sel_a = 1'b1;
                else if (a_nan)      sel_a = 1'b0;
                else if (b_nan)      sel_a = 1'b1;
                else if (op == OP_MIN) sel_a = eq || lt;
                else                 sel_a = !lt;
                flag_d = sel_a;
                res_d  = sel_a ? inA : inB;
            end
        endcase
    end

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign flag      = flag_q[STAGES-1];
    assign res       = res_q[STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            flag_q <= '0;
            for (int i = 0; i < STAGES; i++) res_q[i] <= '0;
        end else if (en) begin
            vld_q[0]  <= in_valid;
            flag_q[0] <= flag_d;
            res_q[0]  <= res_d;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i]  <= vld_q[i-1];
                flag_q[i] <= flag_q[i-1];
                res_q[i]  <= res_q[i-1];
            end
        end
    end

`ifdef FP_COMPARE_UNORD_EN
    logic [STAGES-1:0] unord_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unord_q <= '0;
        end else if (en) begin
            unord_q[0] <= any_nan;
            for (int i = 1; i < STAGES; i++) unord_q[i] <= unord_q[i-1];
        end
    end

    assign unord = unord_q[STAGES-1];
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed-vector bench for fp_compare_pipe (STAGES=2, WE=WF=11); optionally checks 'unord'
// when FP_COMPARE_UNORD_EN is defined.
module tb_fp_compare_pipe;

    localparam int WE     = 11;
    localparam int WF     = 11;
    localparam int STAGES = 2;
    localparam int W      = WE + WF + 3;

    localparam logic [2:0] OP_GE  = 3'b000;
    localparam logic [2:0] OP_GT  = 3'b001;
    localparam logic [2:0] OP_LE  = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_NE  = 3'b101;
    localparam logic [2:0] OP_MIN = 3'b110;
    localparam logic [2:0] OP_MAX = 3'b111;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] inA, inB;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         flag;
    logic [W-1:0] res;
`ifdef FP_COMPARE_UNORD_EN
    logic         unord;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fp_compare_pipe #(.WE(WE), .WF(WF), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_COMPARE_UNORD_EN
        .unord     (unord),
`endif
        .flag      (flag),
        .res       (res)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fp(input logic [1:0] exn, input logic s,
                                        input logic [10:0] e, input logic [10:0] f);
        return {exn, s, e, f};
    endfunction

    // Bias 1023: 3.0 = 1.5*2^1, 2.0 = 1.0*2^1, 1.5 = 1.5*2^0, 1.0 = 1.0*2^0.
    logic [W-1:0] P3, P2, P1, PZ, NZ, NAN, NAN2, NINF, PINF, N2, N15;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer with out_ready held high; checks latency, flag and res.
    task automatic run_one(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ef, input logic [W-1:0] er);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        inA       = a;
        inB       = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = ~o;
        inA      = ~a;
        inB      = ~b;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(STAGES));
        check({tag, ".flag"}, 64'(flag), 64'(ef));
        check({tag, ".res"}, 64'(res), 64'(er));
`ifdef FP_COMPARE_UNORD_EN
        check({tag, ".unord"}, 64'(unord), 64'((a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11)));
`endif
    endtask

    logic [2:0]   s_op  [4];
    logic [W-1:0] s_a   [4];
    logic [W-1:0] s_b   [4];
    logic         s_flg [4];
    logic [W-1:0] s_res [4];

    initial begin
        int tx, rx, extra;

        P3   = fp(2'b01, 1'b0, 11'd1024, 11'h400);
        P2   = fp(2'b01, 1'b0, 11'd1024, 11'h000);
        P1   = fp(2'b01, 1'b0, 11'd1023, 11'h000);
        N2   = fp(2'b01, 1'b1, 11'd1024, 11'h000);
        N15  = fp(2'b01, 1'b1, 11'd1023, 11'h400);
        PZ   = fp(2'b00, 1'b0, 11'd0, 11'd0);
        NZ   = fp(2'b00, 1'b1, 11'd0, 11'd0);
        NAN  = fp(2'b11, 1'b0, 11'd0, 11'd0);
        NAN2 = fp(2'b11, 1'b1, 11'd5, 11'd7);
        NINF = fp(2'b10, 1'b1, 11'd0, 11'd0);
        PINF = fp(2'b10, 1'b0, 11'd0, 11'd0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; inA = '0; inB = '0;
        #2;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.flag", 64'(flag), 64'd0);
        check("reset.res", 64'(res), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_one("ge_3_2",      OP_GE,  P3,   P2,   1'b1, P3);
        run_one("gt_2_3",      OP_GT,  P2,   P3,   1'b0, P2);
        run_one("eq_pz_nz",    OP_EQ,  PZ,   NZ,   1'b1, PZ);
        run_one("lt_pz_nz",    OP_LT,  PZ,   NZ,   1'b0, PZ);
        run_one("max_nan_ninf",OP_MAX, NAN,  NINF, 1'b0, NINF);
        run_one("lt_n2_n15",   OP_LT,  N2,   N15,  1'b1, N2);
        run_one("gt_n2_n15",   OP_GT,  N2,   N15,  1'b0, N2);
        run_one("min_3_2",     OP_MIN, P3,   P2,   1'b0, P2);
        run_one("max_3_2",     OP_MAX, P3,   P2,   1'b1, P3);
        run_one("min_nz_pz",   OP_MIN, NZ,   PZ,   1'b1, NZ);
        run_one("ne_1_nan",    OP_NE,  P1,   NAN,  1'b1, P1);
        run_one("eq_nan_nan",  OP_EQ,  NAN,  NAN,  1'b0, NAN);
        run_one("le_2_2",      OP_LE,  P2,   P2,   1'b1, P2);
        run_one("ge_ninf_n2",  OP_GE,  NINF, N2,   1'b0, NINF);
        run_one("lt_n15_pz",   OP_LT,  N15,  PZ,   1'b1, N15);
        run_one("max_nan_nan", OP_MAX, NAN,  NAN2, 1'b1, NAN);
        run_one("min_pinf_nan",OP_MIN, PINF, NAN,  1'b1, PINF);
        run_one("gt_pinf_3",   OP_GT,  PINF, P3,   1'b1, PINF);

        // Back-to-back stream with out_ready low for cycles 3..5.
        s_op[0] = OP_GE;  s_a[0] = P3;   s_b[0] = P2;  s_flg[0] = 1'b1; s_res[0] = P3;
        s_op[1] = OP_MIN; s_a[1] = P3;   s_b[1] = P2;  s_flg[1] = 1'b0; s_res[1] = P2;
        s_op[2] = OP_LT;  s_a[2] = N2;   s_b[2] = N15; s_flg[2] = 1'b1; s_res[2] = N2;
        s_op[3] = OP_MAX; s_a[3] = NINF; s_b[3] = P1;  s_flg[3] = 1'b0; s_res[3] = P1;
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (tx < 4) begin
                in_valid = 1'b1; op = s_op[tx]; inA = s_a[tx]; inB = s_b[tx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check("stream.stall_in_ready", 64'(in_ready), 64'd0);
                check("stream.stall_res", 64'(res), 64'(s_res[rx]));
            end
            if (out_valid && out_ready) begin
                check("stream.flag", 64'(flag), 64'(s_flg[rx]));
                check("stream.res", 64'(res), 64'(s_res[rx]));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        check("stream.count", 64'(rx), 64'd4);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) extra++;
        end
        check("stream.no_duplicate", 64'(extra), 64'd0);

        // Reset with two results in flight.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = OP_GE; inA = P3; inB = P2;
        @(posedge clk); #1;
        op = OP_LT; inA = N2; inB = N15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rst.inflight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.flag", 64'(flag), 64'd0);
        check("rst.res", 64'(res), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("rst.no_stale", 64'(extra), 64'd0);
        run_one("post_rst_eq", OP_EQ, P1, P1, 1'b1, P1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
